hdmi_cfg_seq: RTL and testbench
===============================

Name: hdmi_cfg_seq

Overview:
- Power-up configuration sequencer for the HDMI transmitter.
- Walks a fixed table of (register, value) writes and issues each one as an I2C write transaction to the byte-level I2C master through a req/done handshake.
- Retries NACKed or timed-out writes, then reports done or error.
- Sits between reset/board control and the I2C master. The HDMI timing generator is gated on cfg_done.

Parameters:
- DEV_ADDR, 7'h39, 7-bit I2C address of the HDMI transmitter.
- NUM_ENTRIES, 16, number of table entries (1..256).
- STARTUP_DELAY, 4190, cycles to wait after reset before the first write (about 1 ms at 4.19 MHz).
- GAP_CYCLES, 8, idle cycles between consecutive transactions.
- TIMEOUT, 2048, maximum cycles to wait for i2c_done per attempt.
- MAX_RETRY, 3, extra attempts per entry after the first failure.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; re-runs the sequence from DONE or ERROR.
- i2c_req  out  1  transaction request; level signal.
- i2c_dev_addr  out  7  device address; always DEV_ADDR.
- i2c_reg_addr  out  8  register sub-address.
- i2c_wdata  out  8  data byte.
- i2c_done  in  1  single-cycle pulse; current transaction finished.
- i2c_nack  in  1  valid only when i2c_done=1; 1 = the slave NACKed.
- cfg_busy  out  1  sequence in progress.
- cfg_done  out  1  all entries written successfully; sticky.
- cfg_error  out  1  an entry exhausted its retries; sticky.
- cfg_index  out  8  index of the current or failing entry.

Behaviour:
- Reset values:
  - i2c_req=0, cfg_done=0, cfg_error=0, cfg_index=0.
  - i2c_reg_addr=0, i2c_wdata=0.
  - cfg_busy=1, because reset enters WAIT_PWR.
  - All counters cleared.
- rst asserted in any state, including mid-transaction, returns the block to WAIT_PWR next cycle with req dropped. The master must tolerate req falling before done.
- States:
  - WAIT_PWR: count STARTUP_DELAY cycles, then go to ISSUE with index=0.
  - ISSUE: latch table[index] onto reg_addr/wdata, set i2c_req=1, clear the timeout counter, go to WAIT_ACK. Address and data are registered and stay stable while req=1.
  - WAIT_ACK: hold req. Outcomes:
    - Success: i2c_done=1 and i2c_nack=0.
    - Failure: i2c_done=1 and i2c_nack=1, or timeout counter reaches TIMEOUT-1 with no done.
    - req deasserts in the cycle after done or timeout is seen.
    - After success: if index==NUM_ENTRIES-1, go to DONE; otherwise index+1 and go to GAP.
    - After failure: if retry<MAX_RETRY, retry+1 and go to GAP with index unchanged; otherwise go to ERROR.
    - Retry count clears whenever an entry succeeds.
  - GAP: count GAP_CYCLES, then go to ISSUE.
  - DONE: cfg_done=1, cfg_busy=0. A start pulse clears cfg_done, sets index=0 and goes to ISSUE, without the startup delay.
  - ERROR: cfg_error=1, cfg_busy=0, cfg_index frozen on the failing entry. A start pulse clears cfg_error and re-runs from index 0.
- start in any other state is ignored.
- Boundary cases:
  - done coincident with the timeout terminal count: done wins.
  - done while not in WAIT_ACK: ignored.
- Latency: first req is asserted STARTUP_DELAY+1 cycles after rst falls.
- Counters are sized with $clog2 of their parameter. Index is 8 bits and never wraps past NUM_ENTRIES-1.

Decomposition:
- Shared package (constants.sv):
  - cfg_state_t enum (WAIT_PWR, ISSUE, WAIT_ACK, GAP, DONE, ERROR).
  - cfg_entry_t struct {reg_addr[7:0], data[7:0]}.
  - HDMI_I2C_ADDR constant.
- Sub-module hdmi_cfg_rom: combinational lookup from index[7:0] to cfg_entry_t holding the transmitter init table. Entries beyond the table return {8'hFF, 8'h00}.
- The sequencer holds only control logic.

Test Plan:
- Reset then ACK every transaction (NUM_ENTRIES=4, STARTUP_DELAY=10, GAP=2) -> first req at cycle 11 after rst falls; 4 transactions whose reg/data match the ROM in order; cfg_done=1 and cfg_busy=0 afterwards; no further req.
- Entry 2 NACKed twice then ACKed -> entry 2 issued 3 times with identical reg/data and GAP_CYCLES between attempts; cfg_done=1; cfg_error=0.
- Entry 1 NACKed on every attempt (MAX_RETRY=3) -> exactly 4 attempts; cfg_error=1, cfg_index=1, cfg_busy=0; entry 2 never issued.
- Master never pulses done (TIMEOUT=16) -> req held 16 cycles then dropped; retries follow the failure path; final cfg_error=1, cfg_index=0.
- rst pulsed in WAIT_ACK of entry 3 -> req=0 next cycle; cfg_index=0; STARTUP_DELAY re-elapses before the first req; full sequence completes.
- start pulse in DONE -> cfg_done=0 next cycle; index-0 req follows without startup delay. start pulse during WAIT_ACK -> no effect.

Source files
------------

// File: rtl/hdmi_cfg_seq_pkg.sv
// Shared types and constants for the HDMI transmitter power-up configuration
// sequencer: FSM state encoding, configuration table entry layout, device address.
package hdmi_cfg_seq_pkg;

    // 7-bit I2C address of the HDMI transmitter.
    localparam logic [6:0] HDMI_I2C_ADDR = 7'h39;

    // Number of entries actually populated in the init table.
    localparam int ROM_DEPTH = 16;

    // Sequencer states.
    typedef enum logic [2:0] {
        WAIT_PWR = 3'd0,
        ISSUE    = 3'd1,
        WAIT_ACK = 3'd2,
        GAP      = 3'd3,
        DONE     = 3'd4,
        ERROR    = 3'd5
    } cfg_state_t;

    // One configuration write: transmitter register sub-address and data byte.
    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } cfg_entry_t;

    // Counter width for a count of n cycles; never narrower than one bit so
    // that a parameter of 1 still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hdmi_cfg_seq_rom.sv
// Transmitter init table: combinational lookup from entry index to
// (register, value). Indices past the populated table return {8'hFF, 8'h00}.
module hdmi_cfg_seq_rom
    import hdmi_cfg_seq_pkg::*;
(
    input  logic [7:0] i_index,
    output cfg_entry_t o_entry
);

    // Table lookup; out-of-range indices fall through to the filler entry.
    always_comb begin
        o_entry = '{reg_addr: 8'hFF, data: 8'h00};
        case (i_index)
            8'd0:  o_entry = '{reg_addr: 8'h41, data: 8'h10}; // power up TX
            8'd1:  o_entry = '{reg_addr: 8'h98, data: 8'h03}; // fixed init
            8'd2:  o_entry = '{reg_addr: 8'h9A, data: 8'hE0}; // fixed init
            8'd3:  o_entry = '{reg_addr: 8'h9C, data: 8'h30}; // PLL filter
            8'd4:  o_entry = '{reg_addr: 8'h9D, data: 8'h61}; // clock divide
            8'd5:  o_entry = '{reg_addr: 8'hA2, data: 8'hA4}; // fixed init
            8'd6:  o_entry = '{reg_addr: 8'hA3, data: 8'hA4}; // fixed init
            8'd7:  o_entry = '{reg_addr: 8'hE0, data: 8'hD0}; // fixed init
            8'd8:  o_entry = '{reg_addr: 8'hF9, data: 8'h00}; // fixed I2C addr
            8'd9:  o_entry = '{reg_addr: 8'h15, data: 8'h00}; // input ID: RGB 4:4:4
            8'd10: o_entry = '{reg_addr: 8'h16, data: 8'h30}; // 8-bit colour depth
            8'd11: o_entry = '{reg_addr: 8'h17, data: 8'h02}; // 16:9 aspect
            8'd12: o_entry = '{reg_addr: 8'h18, data: 8'h46}; // CSC off
            8'd13: o_entry = '{reg_addr: 8'hAF, data: 8'h06}; // HDMI mode
            8'd14: o_entry = '{reg_addr: 8'h40, data: 8'h80}; // GC packet enable
            8'd15: o_entry = '{reg_addr: 8'h55, data: 8'h10}; // AVI: RGB
            default: o_entry = '{reg_addr: 8'hFF, data: 8'h00};
        endcase
    end

endmodule

// File: rtl/hdmi_cfg_seq.sv
// HDMI transmitter power-up configuration sequencer. After a startup delay it
// walks the init table and issues one I2C write per entry to the byte-level
// I2C master, retrying NACKed or timed-out writes, then reports done or error.
//
// Master handshake: o_i2c_req is a level. Once raised it stays high, with
// o_i2c_dev_addr/o_i2c_reg_addr/o_i2c_wdata held stable, until the master
// returns a one-cycle i_i2c_done (i_i2c_nack qualifies it) or the per-attempt
// timeout expires; req drops the cycle after either is seen. Reset may drop
// req before done arrives, and the master has to tolerate that.
module hdmi_cfg_seq
    import hdmi_cfg_seq_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR      = HDMI_I2C_ADDR,
    parameter int         NUM_ENTRIES   = 16,
    parameter int         STARTUP_DELAY = 4190,
    parameter int         GAP_CYCLES    = 8,
    parameter int         TIMEOUT       = 2048,
    parameter int         MAX_RETRY     = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic       o_i2c_req,
    output logic [6:0] o_i2c_dev_addr,
    output logic [7:0] o_i2c_reg_addr,
    output logic [7:0] o_i2c_wdata,
    input  logic       i_i2c_done,
    input  logic       i_i2c_nack,
    output logic       o_cfg_busy,
    output logic       o_cfg_done,
    output logic       o_cfg_error,
    output logic [7:0] o_cfg_index,
    output cfg_state_t o_state
);

    localparam int PWR_W = cnt_width(STARTUP_DELAY);
    localparam int GAP_W = cnt_width(GAP_CYCLES);
    localparam int TO_W  = cnt_width(TIMEOUT);
    localparam int RTY_W = cnt_width(MAX_RETRY + 1);

    // Terminal counts, cast to the counter widths so compares are width-exact.
    localparam logic [PWR_W-1:0] PWR_LAST   = PWR_W'(STARTUP_DELAY - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RETRY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [7:0]       INDEX_LAST = 8'(NUM_ENTRIES - 1);

    cfg_state_t       r_state;
    logic [PWR_W-1:0] r_pwr_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [RTY_W-1:0] r_retry;
    logic [7:0]       r_index;
    logic             r_req;
    logic [7:0]       r_reg_addr;
    logic [7:0]       r_wdata;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    cfg_entry_t       w_entry;
    logic             w_ack_ok;
    logic             w_ack_fail;

    hdmi_cfg_seq_rom u_rom (
        .i_index (r_index),
        .o_entry (w_entry)
    );

    // Attempt outcome in WAIT_ACK. A done arriving on the timeout terminal
    // count is taken as the master's answer, so done is checked first.
    assign w_ack_ok   = i_i2c_done && !i_i2c_nack;
    assign w_ack_fail = (i_i2c_done && i_i2c_nack) ||
                        (!i_i2c_done && (r_to_cnt == TO_LAST));

    // Sequencer FSM: counters, table index, retries and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= WAIT_PWR;
            r_pwr_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_to_cnt   <= '0;
            r_retry    <= '0;
            r_index    <= 8'd0;
            r_req      <= 1'b0;
            r_reg_addr <= 8'd0;
            r_wdata    <= 8'd0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                WAIT_PWR: begin
                    if (r_pwr_cnt == PWR_LAST) begin
                        r_pwr_cnt <= '0;
                        r_index   <= 8'd0;
                        r_state   <= ISSUE;
                    end else begin
                        r_pwr_cnt <= r_pwr_cnt + 1'b1;
                    end
                end

                ISSUE: begin
                    // Address/data are captured here and held for the whole attempt.
                    r_reg_addr <= w_entry.reg_addr;
                    r_wdata    <= w_entry.data;
                    r_req      <= 1'b1;
                    r_to_cnt   <= '0;
                    r_state    <= WAIT_ACK;
                end

                WAIT_ACK: begin
                    if (w_ack_ok) begin
                        r_req   <= 1'b0;
                        r_retry <= '0;
                        if (r_index == INDEX_LAST) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_index <= r_index + 8'd1;
                            r_state <= GAP;
                        end
                    end else if (w_ack_fail) begin
                        r_req <= 1'b0;
                        if (r_retry < RETRY_MAX) begin
                            r_retry <= r_retry + 1'b1;
                            r_state <= GAP;
                        end else begin
                            // Index stays on the failing entry for diagnosis.
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ERROR;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt <= '0;
                        r_state   <= ISSUE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                DONE: begin
                    // Re-run skips the startup delay: the transmitter is already powered.
                    if (i_start) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_index <= 8'd0;
                        r_retry <= '0;
                        r_state <= ISSUE;
                    end
                end

                ERROR: begin
                    if (i_start) begin
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        r_index <= 8'd0;
                        r_retry <= '0;
                        r_state <= ISSUE;
                    end
                end

                default: begin
                    r_state <= WAIT_PWR;
                end
            endcase
        end
    end

    assign o_i2c_req      = r_req;
    assign o_i2c_dev_addr = DEV_ADDR;
    assign o_i2c_reg_addr = r_reg_addr;
    assign o_i2c_wdata    = r_wdata;
    assign o_cfg_busy     = r_busy;
    assign o_cfg_done     = r_done;
    assign o_cfg_error    = r_error;
    assign o_cfg_index    = r_index;
    assign o_state        = r_state;

endmodule

// File: tb/tb_hdmi_cfg_seq.sv
// Self-checking bench for hdmi_cfg_seq: table-driven master responses plus
// hand-written reset, start and ignored-input sequences.
`timescale 1ns/1ps
module tb_hdmi_cfg_seq;
    import hdmi_cfg_seq_pkg::*;

    localparam int NE = 4;
    localparam int SD = 10;
    localparam int GC = 2;
    localparam int TO = 16;
    localparam int MR = 3;

    localparam int R_ACK      = 0;
    localparam int R_NACK     = 1;
    localparam int R_SILENT   = 2;
    localparam int R_ACK_TERM = 3;

    // One transaction: how the modelled master answers, and which entry
    // the sequencer should be presenting.
    typedef struct {
        int         resp;
        int         delay;
        bit         start_mid;
        logic [7:0] exp_index;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       i2c_done = 1'b0;
    logic       i2c_nack = 1'b0;
    logic       req;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_error;
    logic [7:0] cfg_index;
    cfg_state_t dbg_state;

    always #5 clk = ~clk;

    hdmi_cfg_seq #(
        .DEV_ADDR      (7'h39),
        .NUM_ENTRIES   (NE),
        .STARTUP_DELAY (SD),
        .GAP_CYCLES    (GC),
        .TIMEOUT       (TO),
        .MAX_RETRY     (MR)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .o_i2c_req      (req),
        .o_i2c_dev_addr (dev_addr),
        .o_i2c_reg_addr (reg_addr),
        .o_i2c_wdata    (wdata),
        .i_i2c_done     (i2c_done),
        .i_i2c_nack     (i2c_nack),
        .o_cfg_busy     (cfg_busy),
        .o_cfg_done     (cfg_done),
        .o_cfg_error    (cfg_error),
        .o_cfg_index    (cfg_index),
        .o_state        (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_word;
    logic        prev_req = 1'b0;
    logic [7:0]  rom_reg [0:NE-1];
    logic [7:0]  rom_dat [0:NE-1];
    vec_t        vecs [0:15];
    int          nvec = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every rising req must match the next expected {reg, data}.
    always @(negedge clk) begin
        if (req && !prev_req) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req actual reg=%0h data=%0h expected no request", reg_addr, wdata);
            end else begin
                exp_word = exp_q.pop_front();
                check("req_payload", {16'd0, reg_addr, wdata}, {16'd0, exp_word});
            end
        end
        prev_req = req;
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input int idx);
        exp_q.push_back({rom_reg[idx], rom_dat[idx]});
    endtask

    task automatic add_vec(input int resp, input int delay, input bit start_mid, input int idx);
        vecs[nvec].resp      = resp;
        vecs[nvec].delay     = delay;
        vecs[nvec].start_mid = start_mid;
        vecs[nvec].exp_index = 8'(idx);
        nvec++;
        push_exp(idx);
    endtask

    task automatic wait_req(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int k = 0; k < SD + 60; k++) begin
            @(negedge clk);
            cycles++;
            if (req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic respond(input vec_t v);
        int high;
        high = 1;
        if (v.start_mid) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            high++;
            check("start_in_wait_ack_req", 32'(req), 32'd1);
            check("start_in_wait_ack_index", 32'(cfg_index), 32'(v.exp_index));
        end
        case (v.resp)
            R_ACK, R_NACK: begin
                repeat (v.delay) begin
                    @(negedge clk);
                    high++;
                end
                check("req_held", 32'(req), 32'd1);
                i2c_done = 1'b1;
                i2c_nack = (v.resp == R_NACK);
                @(negedge clk);
                i2c_done = 1'b0;
                i2c_nack = 1'b0;
                check("req_drop", 32'(req), 32'd0);
            end
            R_ACK_TERM: begin
                while (high < TO) begin
                    @(negedge clk);
                    high++;
                end
                check("req_at_terminal", 32'(req), 32'd1);
                i2c_done = 1'b1;
                i2c_nack = 1'b0;
                @(negedge clk);
                i2c_done = 1'b0;
                check("req_drop_terminal", 32'(req), 32'd0);
            end
            default: begin
                while (req && high <= TO + 4) begin
                    @(negedge clk);
                    if (req) high++;
                end
                check("timeout_req_len", 32'(high), 32'(TO));
            end
        endcase
    endtask

    task automatic run_vectors(input int first_lat);
        int cyc;
        bit ok;
        for (int i = 0; i < nvec; i++) begin
            wait_req(cyc, ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL req_wait vec=%0d actual no request expected request within %0d cycles", i, SD + 60);
                return;
            end
            if (i == 0) check("first_req_latency", 32'(cyc), 32'(first_lat));
            else        check("gap_len", 32'(cyc), 32'(GC + 1));
            check("req_index", 32'(cfg_index), 32'(vecs[i].exp_index));
            check("req_busy", 32'(cfg_busy), 32'd1);
            check("dev_addr", 32'(dev_addr), 32'h39);
            respond(vecs[i]);
        end
        nvec = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog actual still running expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- test sequence ----------------
    initial begin
        int cyc;
        bit ok;
        rom_reg[0] = 8'h41; rom_dat[0] = 8'h10;
        rom_reg[1] = 8'h98; rom_dat[1] = 8'h03;
        rom_reg[2] = 8'h9A; rom_dat[2] = 8'hE0;
        rom_reg[3] = 8'h9C; rom_dat[3] = 8'h30;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_req", 32'(req), 32'd0);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_error", 32'(cfg_error), 32'd0);
        check("rst_index", 32'(cfg_index), 32'd0);
        check("rst_reg", 32'(reg_addr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_busy", 32'(cfg_busy), 32'd1);
        check("rst_state", 32'(dbg_state), 32'(WAIT_PWR));

        // All entries ACKed; last one answered on the timeout terminal count.
        add_vec(R_ACK, 1, 1'b0, 0);
        add_vec(R_ACK, 0, 1'b0, 1);
        add_vec(R_ACK, 2, 1'b0, 2);
        add_vec(R_ACK_TERM, 0, 1'b0, 3);
        rst = 1'b0;
        run_vectors(SD + 1);
        check("s1_done", 32'(cfg_done), 32'd1);
        check("s1_busy", 32'(cfg_busy), 32'd0);
        check("s1_error", 32'(cfg_error), 32'd0);
        repeat (20) @(negedge clk);
        check("s1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("s1_state", 32'(dbg_state), 32'(DONE));

        // Restart from DONE; entry 2 NACKed twice then ACKed; start ignored mid-transaction.
        add_vec(R_ACK, 0, 1'b0, 0);
        add_vec(R_ACK, 2, 1'b1, 1);
        add_vec(R_NACK, 1, 1'b0, 2);
        add_vec(R_NACK, 0, 1'b0, 2);
        add_vec(R_ACK, 0, 1'b0, 2);
        add_vec(R_ACK, 0, 1'b0, 3);
        pulse_start();
        check("s2_done_cleared", 32'(cfg_done), 32'd0);
        check("s2_busy_set", 32'(cfg_busy), 32'd1);
        run_vectors(1);
        check("s2_done", 32'(cfg_done), 32'd1);
        check("s2_error", 32'(cfg_error), 32'd0);
        // Stray done outside WAIT_ACK.
        i2c_done = 1'b1;
        i2c_nack = 1'b1;
        @(negedge clk);
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        repeat (5) @(negedge clk);
        check("s2_stray_done_state", 32'(dbg_state), 32'(DONE));
        check("s2_stray_done_error", 32'(cfg_error), 32'd0);

        // Entry 1 NACKed on every attempt: 1 + MAX_RETRY attempts then ERROR.
        add_vec(R_ACK, 0, 1'b0, 0);
        for (int k = 0; k <= MR; k++) add_vec(R_NACK, k, 1'b0, 1);
        pulse_start();
        run_vectors(1);
        check("s3_error", 32'(cfg_error), 32'd1);
        check("s3_index", 32'(cfg_index), 32'd1);
        check("s3_busy", 32'(cfg_busy), 32'd0);
        check("s3_done", 32'(cfg_done), 32'd0);
        repeat (20) @(negedge clk);
        check("s3_queue_empty", 32'(exp_q.size()), 32'd0);
        i2c_done = 1'b1;
        @(negedge clk);
        i2c_done = 1'b0;
        repeat (3) @(negedge clk);
        check("s3_stray_done_state", 32'(dbg_state), 32'(ERROR));
        check("s3_stray_done_index", 32'(cfg_index), 32'd1);

        // Master never answers: every attempt on entry 0 times out.
        for (int k = 0; k <= MR; k++) add_vec(R_SILENT, 0, 1'b0, 0);
        pulse_start();
        check("s4_error_cleared", 32'(cfg_error), 32'd0);
        check("s4_busy_set", 32'(cfg_busy), 32'd1);
        run_vectors(1);
        check("s4_error", 32'(cfg_error), 32'd1);
        check("s4_index", 32'(cfg_index), 32'd0);
        check("s4_busy", 32'(cfg_busy), 32'd0);

        // Reset during WAIT_ACK of entry 3, then a full sequence from power-up.
        add_vec(R_ACK, 0, 1'b0, 0);
        add_vec(R_ACK, 0, 1'b0, 1);
        add_vec(R_ACK, 0, 1'b0, 2);
        push_exp(3);
        pulse_start();
        run_vectors(1);
        wait_req(cyc, ok);
        check("s5_entry3_req", 32'(ok), 32'd1);
        check("s5_entry3_index", 32'(cfg_index), 32'd3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("s5_rst_req", 32'(req), 32'd0);
        check("s5_rst_index", 32'(cfg_index), 32'd0);
        check("s5_rst_busy", 32'(cfg_busy), 32'd1);
        check("s5_rst_state", 32'(dbg_state), 32'(WAIT_PWR));
        check("s5_queue_empty", 32'(exp_q.size()), 32'd0);
        for (int k = 0; k < NE; k++) add_vec(R_ACK, k % 2, 1'b0, k);
        rst = 1'b0;
        run_vectors(SD + 1);
        check("s5_done", 32'(cfg_done), 32'd1);
        check("s5_error", 32'(cfg_error), 32'd0);
        repeat (10) @(negedge clk);
        check("s5_final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
